// File: rtl/logic_op_checker.sv
// Self-checking receiver for 8-bit NOT/XOR/NAND/NOR units: recomputes each result in a 2-stage pipeline and tallies mismatches.
// Optional idle watchdog is compiled in with `define LOGIC_CHK_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | waiting for start after reset
// RUN    | accepting operand/result beats until num_txn transfers seen
// DRAIN  | no new beats; letting the compare pipeline retire
// DONE   | results held; start re-arms
module logic_op_checker #(
    parameter int WIDTH   = 8,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [CNT_W-1:0] num_txn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] txn_count,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [WIDTH-1:0] first_err_exp,
    output logic [WIDTH-1:0] first_err_got,
    output logic             timeout
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [CNT_W-1:0] num_txn_q, num_txn_d;
    logic [CNT_W-1:0] txn_count_q, txn_count_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic [CNT_W-1:0] first_err_idx_q, first_err_idx_d;
    logic [WIDTH-1:0] first_err_exp_q, first_err_exp_d;
    logic [WIDTH-1:0] first_err_got_q, first_err_got_d;

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    logic [WIDTH-1:0] s1_got_q, s1_got_d;
    logic [CNT_W-1:0] s1_idx_q, s1_idx_d;

    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_exp_q, s2_exp_d;
    logic [WIDTH-1:0] s2_got_q, s2_got_d;
    logic [CNT_W-1:0] s2_idx_q, s2_idx_d;

    logic             in_ready_w;
    logic             xfer;
    logic [WIDTH-1:0] exp_w;

`ifdef LOGIC_CHK_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            timeout_q, timeout_d;
`endif

    assign in_ready_w = (state_q == S_RUN) && (txn_count_q < num_txn_q);
    assign xfer       = in_valid && in_ready_w;

    always_comb begin
        exp_w = '0;
        case (op_q)
            2'b00:   exp_w = ~s1_a_q;
            2'b01:   exp_w = s1_a_q ^ s1_b_q;
            2'b10:   exp_w = ~(s1_a_q & s1_b_q);
            default: exp_w = ~(s1_a_q | s1_b_q);
        endcase
    end

    always_comb begin
        state_d         = state_q;
        op_d            = op_q;
        num_txn_d       = num_txn_q;
        txn_count_d     = txn_count_q;
        err_count_d     = err_count_q;
        first_err_idx_d = first_err_idx_q;
        first_err_exp_d = first_err_exp_q;
        first_err_got_d = first_err_got_q;
        s1_valid_d      = xfer;
        s1_a_d          = s1_a_q;
        s1_b_d          = s1_b_q;
        s1_got_d        = s1_got_q;
        s1_idx_d        = s1_idx_q;
        s2_valid_d      = s1_valid_q;
        s2_exp_d        = s2_exp_q;
        s2_got_d        = s2_got_q;
        s2_idx_d        = s2_idx_q;
`ifdef LOGIC_CHK_TIMEOUT_EN
        wd_d            = wd_q;
        timeout_d       = timeout_q;
`endif

        if (xfer) begin
            s1_a_d      = in_a;
            s1_b_d      = in_b;
            s1_got_d    = dut_out;
            s1_idx_d    = txn_count_q;
            txn_count_d = txn_count_q + 1'b1;
        end

        if (s1_valid_q) begin
            s2_exp_d = exp_w;
            s2_got_d = s1_got_q;
            s2_idx_d = s1_idx_q;
        end

        if (s2_valid_q && (s2_exp_q != s2_got_q)) begin
            if (err_count_q == '0) begin
                first_err_idx_d = s2_idx_q;
                first_err_exp_d = s2_exp_q;
                first_err_got_d = s2_got_q;
            end
            if (err_count_q != '1) begin
                err_count_d = err_count_q + 1'b1;
            end
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    op_d            = op;
                    num_txn_d       = num_txn;
                    txn_count_d     = '0;
                    err_count_d     = '0;
                    first_err_idx_d = '0;
                    first_err_exp_d = '0;
                    first_err_got_d = '0;
`ifdef LOGIC_CHK_TIMEOUT_EN
                    wd_d            = WD_W'(TIMEOUT);
                    timeout_d       = 1'b0;
`endif
                    state_d         = (num_txn == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (txn_count_q == num_txn_q) begin
                    state_d = S_DRAIN;
                end
`ifdef LOGIC_CHK_TIMEOUT_EN
                else if (xfer) begin
                    wd_d = WD_W'(TIMEOUT);
                end else if (in_ready_w) begin
                    if (wd_q <= WD_W'(1)) begin
                        timeout_d = 1'b1;
                        state_d   = S_DRAIN;
                    end else begin
                        wd_d = wd_q - 1'b1;
                    end
                end
`endif
            end
            S_DRAIN: begin
                // Stage 2 retires on this same edge, so stage 1 empty means the tallies are final.
                if (!s1_valid_q) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            op_q            <= '0;
            num_txn_q       <= '0;
            txn_count_q     <= '0;
            err_count_q     <= '0;
            first_err_idx_q <= '0;
            first_err_exp_q <= '0;
            first_err_got_q <= '0;
            s1_valid_q      <= 1'b0;
            s1_a_q          <= '0;
            s1_b_q          <= '0;
            s1_got_q        <= '0;
            s1_idx_q        <= '0;
            s2_valid_q      <= 1'b0;
            s2_exp_q        <= '0;
            s2_got_q        <= '0;
            s2_idx_q        <= '0;
`ifdef LOGIC_CHK_TIMEOUT_EN
            wd_q            <= '0;
            timeout_q       <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            op_q            <= op_d;
            num_txn_q       <= num_txn_d;
            txn_count_q     <= txn_count_d;
            err_count_q     <= err_count_d;
            first_err_idx_q <= first_err_idx_d;
            first_err_exp_q <= first_err_exp_d;
            first_err_got_q <= first_err_got_d;
            s1_valid_q      <= s1_valid_d;
            s1_a_q          <= s1_a_d;
            s1_b_q          <= s1_b_d;
            s1_got_q        <= s1_got_d;
            s1_idx_q        <= s1_idx_d;
            s2_valid_q      <= s2_valid_d;
            s2_exp_q        <= s2_exp_d;
            s2_got_q        <= s2_got_d;
            s2_idx_q        <= s2_idx_d;
`ifdef LOGIC_CHK_TIMEOUT_EN
            wd_q            <= wd_d;
            timeout_q       <= timeout_d;
`endif
        end
    end

`ifdef LOGIC_CHK_TIMEOUT_EN
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign in_ready      = in_ready_w;
    assign busy          = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done          = (state_q == S_DONE);
    assign pass          = done && (err_count_q == '0) && !timeout;
    assign txn_count     = txn_count_q;
    assign err_count     = err_count_q;
    assign first_err_idx = first_err_idx_q;
    assign first_err_exp = first_err_exp_q;
    assign first_err_got = first_err_got_q;

endmodule

// File: tb/tb_logic_op_checker.sv
// Directed plus randomized bench for logic_op_checker against a truth-table reference model.
// The timeout scenario runs only when LOGIC_CHK_TIMEOUT_EN is defined.
module tb_logic_op_checker;

    localparam int W = 8;
    localparam int C = 16;

    logic         clk = 1'b0;
    logic         rst, start, in_valid;
    logic [1:0]   op;
    logic [C-1:0] num_txn;
    logic [W-1:0] in_a, in_b, dut_out;
    logic         in_ready, busy, done, pass, timeout;
    logic [C-1:0] txn_count, err_count, first_err_idx;
    logic [W-1:0] first_err_exp, first_err_got;

    always #5 clk = ~clk;

    logic_op_checker #(.WIDTH(W), .CNT_W(C), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .num_txn(num_txn),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .dut_out(dut_out), .busy(busy), .done(done), .pass(pass),
        .txn_count(txn_count), .err_count(err_count), .first_err_idx(first_err_idx),
        .first_err_exp(first_err_exp), .first_err_got(first_err_got), .timeout(timeout)
    );

    int checks = 0;
    int failures = 0;

    // Reference state: what a run should have produced so far.
    int m_num, m_cnt, m_err, m_fidx, m_fexp, m_fgot, m_to;
    int tt[4] = '{3, 6, 7, 1};  // per-op truth table over (a_bit*2 + b_bit)

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_fn(input int o, input int a, input int b);
        int r = 0;
        for (int i = 0; i < W; i++) begin
            int idx = ((a >> i) % 2) * 2 + ((b >> i) % 2);
            r += ((tt[o] >> idx) % 2) * (1 << i);
        end
        return r;
    endfunction

    task automatic start_run(input int o, input int n);
        op = 2'(o); num_txn = C'(n); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        m_num = n; m_cnt = 0; m_err = 0; m_fidx = 0; m_fexp = 0; m_fgot = 0; m_to = 0;
    endtask

    task automatic beat(input bit v, input int a, input int b, input int got, input bit st);
        int e;
        in_valid = v; in_a = W'(a); in_b = W'(b); dut_out = W'(got);
        start = st; op = 2'($urandom_range(0, 3)); num_txn = C'($urandom_range(0, 5));
        chk("in_ready", {31'd0, in_ready}, {31'd0, m_cnt < m_num});
        if (v && m_cnt < m_num) begin
            e = ref_fn(int'(dut.op_q), a, b);
            if (e != got) begin
                if (m_err == 0) begin m_fidx = m_cnt; m_fexp = e; m_fgot = got; end
                if (m_err < 65535) m_err++;
            end
            m_cnt++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; start = 1'b0;
    endtask

    task automatic finish_check(input string tag, input int max_wait);
        int n = 0;
        while (!done && n < 20) begin @(posedge clk); #1; n++; end
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_latency"}, {31'd0, n <= max_wait}, 32'd1);
        chk({tag, "_txn"}, 32'(txn_count), 32'(m_cnt));
        chk({tag, "_err"}, 32'(err_count), 32'(m_err));
        chk({tag, "_pass"}, {31'd0, pass}, {31'd0, m_err == 0 && m_to == 0});
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_timeout"}, {31'd0, timeout}, 32'(m_to));
        if (m_err > 0) begin
            chk({tag, "_fidx"}, 32'(first_err_idx), 32'(m_fidx));
            chk({tag, "_fexp"}, 32'(first_err_exp), 32'(m_fexp));
            chk({tag, "_fgot"}, 32'(first_err_got), 32'(m_fgot));
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_pass"}, {31'd0, pass}, 32'd0);
        chk({tag, "_txn"}, 32'(txn_count), 32'd0);
        chk({tag, "_err"}, 32'(err_count), 32'd0);
        chk({tag, "_fidx"}, 32'(first_err_idx), 32'd0);
        chk({tag, "_fexp"}, 32'(first_err_exp), 32'd0);
        chk({tag, "_fgot"}, 32'(first_err_got), 32'd0);
        chk({tag, "_timeout"}, {31'd0, timeout}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit observed=expired expected=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        int idle_run;
        bit v;
        int o, a, b, e, got;
        rst = 1'b1; start = 1'b0; op = '0; num_txn = '0;
        in_valid = 1'b0; in_a = '0; in_b = '0; dut_out = '0;
        m_num = 0; m_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // XOR, all correct
        start_run(1, 3);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        beat(1, 5, 5, 0, 0);
        beat(1, 85, 84, 1, 0);
        beat(1, 255, 0, 255, 0);
        finish_check("t1", 2);

        // NAND, first beat wrong; a mid-run start must be ignored
        start_run(2, 2);
        beat(1, 51, 1, 204, 1);
        beat(1, 0, 255, 255, 1);
        finish_check("t2", 2);
        chk("t2_fexp_const", 32'(first_err_exp), 32'd254);

        // NOT with valid held high past the transaction count
        start_run(0, 2);
        repeat (5) beat(1, 50, $urandom_range(0, 255), 205, 0);
        chk("t3_txn_held", 32'(txn_count), 32'd2);
        finish_check("t3", 2);

        // zero-length run
        start_run(3, 0);
        chk("t4_ready", {31'd0, in_ready}, 32'd0);
        finish_check("t4", 0);

        // NOR, reset mid-run with mismatching data already in the pipeline
        start_run(3, 4);
        beat(1, 255, 255, 1, 0);
        beat(1, 255, 255, 1, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_all_zero("t5_rst");
        repeat (3) @(posedge clk);
        #1;
        chk("t5_no_ghost_err", 32'(err_count), 32'd0);
        start_run(3, 4);
        repeat (4) beat(1, 255, 255, 0, 0);
        finish_check("t5", 2);

        // randomized runs with bubbles, injected errors and ignored starts
        for (int r = 0; r < 25; r++) begin
            int guard = 0;
            o = $urandom_range(0, 3);
            start_run(o, $urandom_range(1, 12));
            idle_run = 0;
            while (m_cnt < m_num && guard < 300) begin
                v = ($urandom_range(0, 3) != 0) || (idle_run >= 4);
                idle_run = v ? 0 : idle_run + 1;
                a = $urandom_range(0, 255);
                b = $urandom_range(0, 255);
                e = ref_fn(o, a, b);
                got = ($urandom_range(0, 4) == 0) ? (e ^ $urandom_range(1, 255)) : e;
                beat(v, a, b, got, $urandom_range(0, 7) == 0);
                guard++;
            end
            chk("rand_progress", {31'd0, m_cnt == m_num}, 32'd1);
            finish_check("rand", 2);
        end

`ifdef LOGIC_CHK_TIMEOUT_EN
        start_run(1, 3);
        beat(1, 1, 2, 3, 0);
        for (int i = 1; i <= 8; i++) begin
            chk("t6_idle_ready", {31'd0, in_ready}, 32'd1);
            @(posedge clk); #1;
            chk("t6_timeout_edge", {31'd0, timeout}, {31'd0, i == 8});
        end
        m_to = 1;
        finish_check("t6", 2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/logic_op_checker.md
Name: logic_op_checker

Overview:
Self-checking receiver for the 8-bit bitwise logic units (NOT/XOR/NAND/NOR).
- Accepts a stream of operand pairs plus the unit's observed output over a valid/ready handshake.
- Recomputes the expected result in a 2-stage pipeline and compares it with the observed output.
- Counts transactions and mismatches, and captures the first failure.
- Sits beside the unit under test on the bench, consuming what the stimulus driver produces.

Parameters:
WIDTH, 8, operand/result width in bits
CNT_W, 16, width of transaction and error counters
TIMEOUT, 64, idle-cycle limit for watchdog (used only with LOGIC_CHK_TIMEOUT_EN)

Ports:
clk  in  1  single clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; latches op and num_txn, begins a run
op  in  2  00 NOT(a), 01 a^b, 10 ~(a&b), 11 ~(a|b)
num_txn  in  CNT_W  number of transactions in the run
in_valid  in  1  in_a/in_b/dut_out valid
in_ready  out  1  checker can accept
in_a  in  WIDTH  operand A
in_b  in  WIDTH  operand B (ignored for NOT)
dut_out  in  WIDTH  observed result from unit under test
busy  out  1  high in RUN or DRAIN
done  out  1  high while in DONE
pass  out  1  done && err_count==0 && !timeout
txn_count  out  CNT_W  transactions accepted this run
err_count  out  CNT_W  mismatches this run, saturating
first_err_idx  out  CNT_W  index (0-based) of first mismatch
first_err_exp  out  WIDTH  expected value at first mismatch
first_err_got  out  WIDTH  observed value at first mismatch
timeout  out  1  watchdog fired (0 when feature compiled out)

Behaviour:
- Reset: FSM=IDLE. All outputs 0, including in_ready, pipeline valids, counters, first_err_* and timeout. Reset mid-run aborts immediately, with no partial results retained.
- FSM states are IDLE, RUN, DRAIN, DONE.
  - IDLE + start: latch op and num_txn, clear counters, first_err_* and timeout. Go to RUN, or to DONE if num_txn==0.
  - RUN: in_ready = (txn_count < num_txn). A transfer occurs when in_valid && in_ready. Each transfer increments txn_count. Go to DRAIN in the cycle after txn_count reaches num_txn.
  - DRAIN: in_ready=0. Wait until both pipeline stages are empty, then go to DONE (at most 2 cycles).
  - DONE: done=1, outputs held. start behaves as in IDLE (re-arm). Otherwise stay.
- start while in RUN or DRAIN is ignored.
- Pipeline:
  - Stage 1 registers a, b, dut_out and idx=txn_count on transfer.
  - Stage 2 registers expected=f(op,a,b), got and idx.
  - The compare result updates err_count/first_err_* in the following cycle, so a transfer at cycle N is reflected in err_count at N+2.
- Mismatch = expected != got on all WIDTH bits. err_count saturates at 2^CNT_W-1 and does not wrap.
- first_err_* are written only on the first mismatch of the run (err_count==0 at compare), then frozen.
- in_valid while in_ready=0 is not a transfer; data is ignored and not counted.
- The driver may hold in_valid high continuously, giving one transfer per cycle with no bubbles.
- pass is combinational from done, err_count and timeout.

Optional Feature:
LOGIC_CHK_TIMEOUT_EN
- Defined:
  - In RUN, a watchdog counts consecutive cycles with in_ready=1 and in_valid=0; it resets to 0 on any transfer.
  - On reaching TIMEOUT: set timeout=1 and go to DRAIN, then DONE. pass is then 0 regardless of err_count.
  - Watchdog is cleared on start and on rst.
- Undefined: no watchdog logic; timeout tied 0; RUN waits indefinitely.

Test Plan:
1. op=01, num_txn=3, transfers (5,5,got 0), (85,84,got 1), (255,0,got 255) -> done within 2 cycles after last transfer, txn_count=3, err_count=0, pass=1.
2. op=10, num_txn=2, transfers (51,1,got 204), (0,255,got 255) -> err_count=1, first_err_idx=0, first_err_exp=254, first_err_got=204, pass=0.
3. op=00, num_txn=2, in_valid held high for 5 cycles with (50,x,got 205) -> exactly 2 transfers, in_ready drops after the 2nd, err_count=0. Extra valid beats are not counted.
4. start with num_txn=0 -> DONE the next cycle, pass=1, txn_count=0, in_ready never asserted.
5. op=11, num_txn=4, rst asserted after 2 transfers -> next cycle all outputs 0, IDLE. A new start then runs cleanly to pass=1 with (255,255,got 0) ×4.
6. (with LOGIC_CHK_TIMEOUT_EN, TIMEOUT=8) start num_txn=3, one transfer, then in_valid=0 -> timeout=1 after 8 idle cycles, then done=1, pass=0, txn_count=1.
